// File: rtl/cla_5bit_bist.sv
// cla_5bit_bist: exhaustive self-test driver/checker for a WIDTH-bit carry-lookahead adder.
// Walks every {c_in,a,b} vector, waits SETTLE_CYCLES, and compares the adder result to A+B+C_in.
module cla_5bit_bist #(
    parameter int WIDTH         = 5,
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_CNT_W     = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 halt_on_err,
    output logic [WIDTH-1:0]     a_o,
    output logic [WIDTH-1:0]     b_o,
    output logic                 c_in_o,
    input  logic [WIDTH-1:0]     sum_i,
    input  logic                 c_out_i,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 fail_valid,
    output logic [2*WIDTH:0]     fail_vec
);
    localparam int VW = 2*WIDTH+1;
    localparam int SW = WIDTH+1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [VW-1:0] vec;
    logic [3:0] settle_cnt;
    logic [SW-1:0] expected;
    logic check, mismatch, last, finish, launch;
    logic [ERR_CNT_W-1:0] err_nxt;

    // Operands come straight from the registered vector counter, so they are glitch-free.
    assign {c_in_o, a_o, b_o} = vec;

    always_comb begin
        expected  = SW'(a_o) + SW'(b_o) + SW'(c_in_o);
        launch    = start && (state != RUN);
        check     = (state == RUN) && (settle_cnt == 4'(SETTLE_CYCLES));
        mismatch  = check && ({c_out_i, sum_i} != expected);
        last      = (vec == '1);
        finish    = check && ((mismatch && halt_on_err) || last);
        err_nxt   = (mismatch && (err_count != '1)) ? err_count + 1'b1 : err_count;
        state_nxt = launch ? RUN : finish ? DONE : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else if (launch) begin
            vec        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else if (check) begin
            err_count <= err_nxt;
            if (mismatch && !fail_valid) begin
                fail_vec   <= vec;
                fail_valid <= 1'b1;
            end
            if (finish) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (err_nxt == '0);
            end else begin
                vec        <= vec + 1'b1;
                settle_cnt <= '0;
            end
        end else if (state == RUN) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_cla_5bit_bist.sv
// tb_cla_5bit_bist: drives two BIST instances (default and SETTLE=0/4-bit counter)
// against a fault-injectable behavioural adder and checks results against a vector-walk model.
module tb_cla_5bit_bist;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, halt = 1'b0;
    logic [4:0] a1, b1, s1, a2, b2, s2;
    logic c1, co1, c2, co2;
    logic busy1, done1, pass1, fv1, busy2, done2, pass2, fv2;
    logic [11:0] err1;
    logic [3:0] err2;
    logic [10:0] fvec1, fvec2;
    int fault = 0;
    int total = 0;
    int bad = 0;
    bit bad_tbl[2048];

    typedef struct {
        int fault; bit halt; int err; int first; bit fv; int edges; int err2; int edges2;
    } case_t;
    case_t cases[5];

    always #5 clk = ~clk;

    cla_5bit_bist dut (
        .clk(clk), .rst(rst), .start(start), .halt_on_err(halt),
        .a_o(a1), .b_o(b1), .c_in_o(c1), .sum_i(s1), .c_out_i(co1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .fail_vec(fvec1)
    );

    cla_5bit_bist #(.SETTLE_CYCLES(0), .ERR_CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .start(start), .halt_on_err(halt),
        .a_o(a2), .b_o(b2), .c_in_o(c2), .sum_i(s2), .c_out_i(co2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_valid(fv2), .fail_vec(fvec2)
    );

    // Adder under test: v = {cin,a,b}; fault 1 = sum[0] stuck-0, 2 = c_out stuck-1, 3 = random table.
    function automatic int adder(input int f, input int v);
        int ideal;
        ideal = ((v >> 5) & 31) + (v & 31) + ((v >> 10) & 1);
        return f == 1 ? ideal & 62 : f == 2 ? ideal | 32 : (f == 3 && bad_tbl[v]) ? ideal ^ 1 : ideal;
    endfunction

    always_comb {co1, s1} = 6'(adder(fault, int'({c1, a1, b1})));
    always_comb {co2, s2} = 6'(adder(fault, int'({c2, a2, b2})));

    function automatic void model(input int f, input bit h, input int s, input int w,
                                  output int errs, output int first, output bit fv, output int edges);
        errs = 0; first = 0; fv = 0; edges = 0;
        for (int v = 0; v < 2048; v++) begin
            edges += s + 1;
            if (adder(f, v) != ((v >> 5) & 31) + (v & 31) + ((v >> 10) & 1)) begin
                if (errs < (1 << w) - 1) errs++;
                if (!fv) begin fv = 1; first = v; end
                if (h) break;
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ops1"}, int'({c1, a1, b1}), 0);
        chk({tag, " flags1"}, int'({busy1, done1, pass1, fv1}), 0);
        chk({tag, " err1"}, int'(err1), 0);
        chk({tag, " fvec1"}, int'(fvec1), 0);
        chk({tag, " dut2"}, int'({c2, a2, b2, busy2, done2, pass2, fv2, err2}) | int'(fvec2), 0);
    endtask

    task automatic run(input string tag, input case_t c);
        int n1 = -1;
        int n2 = -1;
        fault = c.fault;
        halt = c.halt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, " busy_at_start"}, int'({busy1, busy2, done1, done2}), 12);
        for (int n = 1; n <= 5000 && (n1 < 0 || n2 < 0); n++) begin
            @(posedge clk);
            #1;
            if (done1 && n1 < 0) n1 = n;
            if (done2 && n2 < 0) n2 = n;
        end
        chk({tag, " edges"}, n1, c.edges);
        chk({tag, " err"}, int'(err1), c.err);
        chk({tag, " fail_valid"}, int'(fv1), int'(c.fv));
        chk({tag, " fail_vec"}, int'(fvec1), c.first);
        chk({tag, " pass"}, int'({pass1, busy1}), c.err == 0 ? 2 : 0);
        chk({tag, " edges2"}, n2, c.edges2);
        chk({tag, " err2"}, int'(err2), c.err2);
        chk({tag, " fail2"}, int'({fv2, fvec2}), int'({c.fv, 11'(c.first)}));
        chk({tag, " pass2"}, int'({pass2, busy2}), c.err2 == 0 ? 2 : 0);
    endtask

    initial begin
        case_t rc;
        cases[0] = '{0, 1'b0, 0,    0, 1'b0, 4096, 0,  2048};
        cases[1] = '{1, 1'b0, 1024, 1, 1'b1, 4096, 15, 2048};
        cases[2] = '{2, 1'b0, 1024, 0, 1'b1, 4096, 15, 2048};
        cases[3] = '{1, 1'b1, 1,    1, 1'b1, 4,    1,  2};
        cases[4] = '{2, 1'b1, 1,    0, 1'b1, 2,    1,  1};
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) run($sformatf("table%0d", i), cases[i]);
        for (int i = 0; i < 5; i++) begin
            for (int v = 0; v < 2048; v++) bad_tbl[v] = (i == 0) ? 1'b0 : ($urandom_range(0, 150) == 0);
            rc.fault = 3;
            rc.halt = 1'($urandom_range(0, 1));
            model(3, rc.halt, 1, 12, rc.err, rc.first, rc.fv, rc.edges);
            model(3, rc.halt, 0, 4, rc.err2, rc.first, rc.fv, rc.edges2);
            run($sformatf("rand%0d", i), rc);
        end
        fault = 0;
        halt = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (1000) @(posedge clk);
        #1 chk("vec_at_1000", int'({c1, a1, b1}), 500);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_ignored", int'({busy1, c1, a1, b1}), 2048 + 500);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_zero("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        run("after_rst", cases[0]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
